alu_exec_pp: RTL and testbench



---
 rtl/alu_exec_pp.sv | 137 +++++++++++++
 tb/tb_alu_exec_pp.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_pp.sv
// Execute-stage ALU: registered single-cycle ops plus an iterative shift-add multiply that stalls upstream.
// Optional macro ALU_MULT_EARLY_TERM_EN: multiply finishes as soon as the remaining multiplier bits are zero.
module alu_exec_pp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [3:0]       ALU_opcode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             valid_out,
    output logic             stall
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLT   = 4'b0011;
    localparam logic [3:0] OP_MULT  = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NEG   = 4'b0111;
    localparam logic [3:0] OP_PASSB = 4'b1010;

    typedef enum logic {IDLE, MULT} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic             valid_out_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CW-1:0]    count_reg;

    logic [WIDTH-1:0] and_vec;
    logic [WIDTH-1:0] or_vec;
    logic [WIDTH-1:0] alu_next;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mcand_next;
    logic [WIDTH-1:0] mplier_next;
    logic [CW-1:0]    count_next;
    logic             mult_done_next;
    logic             mult_bypass;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
        assign and_vec[gi] = A[gi] & B[gi];
        assign or_vec[gi]  = A[gi] | B[gi];
    end

    // Single-cycle result; mult and unknown codes fall to zero (the B==0 early-out relies on this).
    always_comb begin
        alu_next = '0;
        case (ALU_opcode)
            OP_ADD:   alu_next = A + B;
            OP_SUB:   alu_next = A - B;
            OP_AND:   alu_next = and_vec;
            OP_OR:    alu_next = or_vec;
            OP_NEG:   alu_next = '0 - A;
            OP_SLT:   alu_next = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_PASSB: alu_next = B;
            default:  alu_next = '0;
        endcase
    end

    always_comb begin
        acc_next    = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        count_next  = count_reg + CW'(1);
`ifdef ALU_MULT_EARLY_TERM_EN
        mult_done_next = (count_next == CW'(WIDTH)) || (mplier_next == '0);
        mult_bypass    = (B == '0);
`else
        mult_done_next = (count_next == CW'(WIDTH));
        mult_bypass    = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            result_reg    <= '0;
            zero_reg      <= 1'b1;
            valid_out_reg <= 1'b0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            count_reg     <= '0;
        end else begin
            valid_out_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (valid_in) begin
                        if (ALU_opcode == OP_MULT && !mult_bypass) begin
                            mcand_reg  <= A;
                            mplier_reg <= B;
                            acc_reg    <= '0;
                            count_reg  <= '0;
                            state_reg  <= MULT;
                        end else begin
                            result_reg    <= alu_next;
                            zero_reg      <= (alu_next == '0);
                            valid_out_reg <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        acc_reg    <= acc_next;
                        mcand_reg  <= mcand_next;
                        mplier_reg <= mplier_next;
                        count_reg  <= count_next;
                        if (mult_done_next) begin
                            result_reg    <= acc_next;
                            zero_reg      <= (acc_next == '0);
                            valid_out_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign result    = result_reg;
    assign zero      = zero_reg;
    assign valid_out = valid_out_reg;
    assign stall     = (state_reg == MULT);
endmodule

// File: tb/tb_alu_exec_pp.sv
// Self-checking bench for alu_exec_pp: cycle-level reference model plus directed vectors with literal expectations.
module tb_alu_exec_pp;
    localparam int W = 32;
    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, MUL = 4'b0100, AND_ = 4'b0000;
    localparam logic [3:0] OR_ = 4'b0001, NEG = 4'b0111, SLT = 4'b0011, PASSB = 4'b1010;

    logic          clk = 0;
    logic          reset, valid_in, flush;
    logic [3:0]    ALU_opcode;
    logic [W-1:0]  A, B, result;
    logic          zero, valid_out, stall;

    int n_checks = 0;
    int n_errors = 0;
    bit model_on = 0;

    alu_exec_pp #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ALU_opcode(ALU_opcode),
        .A(A), .B(B), .flush(flush), .result(result), .zero(zero),
        .valid_out(valid_out), .stall(stall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Number of iteration cycles a multiply by b occupies; 0 means it completes like a single-cycle op.
    function automatic int exp_lat(input logic [31:0] b);
`ifdef ALU_MULT_EARLY_TERM_EN
        if (b == 0) return 0;
        for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
        return 0;
`else
        return W;
`endif
    endfunction

    function automatic logic [31:0] spec_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, s;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            ADD:     s = longint'(a) + longint'(b);
            SUB:     s = longint'(a) - longint'(b);
            NEG:     s = -longint'(a);
            SLT:     s = (sa < sb) ? 1 : 0;
            PASSB:   s = longint'(b);
            AND_:    return a & b;
            OR_:     return a | b;
            default: s = 0;
        endcase
        return s[31:0];
    endfunction

    function automatic logic [31:0] mul_lo(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        return p[31:0];
    endfunction

    // Reference model: a countdown of remaining multiply cycles and the product it will deliver.
    logic [31:0] m_result = 0, m_prod = 0;
    logic        m_zero = 1, m_valid = 0;
    int          m_busy = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_result <= 0; m_zero <= 1; m_valid <= 0; m_busy <= 0;
        end else if (m_busy != 0) begin
            if (flush) begin
                m_busy <= 0; m_valid <= 0;
            end else begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_result <= m_prod; m_zero <= (m_prod == 0); m_valid <= 1;
                end else m_valid <= 0;
            end
        end else if (valid_in) begin
            if (ALU_opcode == MUL && exp_lat(B) != 0) begin
                m_busy <= exp_lat(B); m_prod <= mul_lo(A, B); m_valid <= 0;
            end else begin
                m_result <= spec_op(ALU_opcode, A, B);
                m_zero   <= (spec_op(ALU_opcode, A, B) == 0);
                m_valid  <= 1;
            end
        end else m_valid <= 0;
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("cmp_result", result, m_result);
            chk("cmp_zero", {31'b0, zero}, {31'b0, m_zero});
            chk("cmp_valid_out", {31'b0, valid_out}, {31'b0, m_valid});
            chk("cmp_stall", {31'b0, stall}, {31'b0, (m_busy != 0)});
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        valid_in = 1; ALU_opcode = op; A = a; B = b;
        $display("issue op=%b A=%h B=%h flush=%0b", op, a, b, flush);
    endtask

    task automatic idle();
        valid_in = 0; ALU_opcode = 4'b0; A = 0; B = 0;
    endtask

    // Issue a multiply and wait out the stall; returns on the first negedge with stall low.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b, output int cyc);
        issue(MUL, a, b);
        @(negedge clk);
        idle();
        cyc = 0;
        while (stall && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    int cyc;

    initial begin
        reset = 1; flush = 0; idle();
        repeat (2) @(negedge clk);
        model_on = 1;
        chk("rst_result", result, 0);
        chk("rst_zero", {31'b0, zero}, 1);
        chk("rst_valid", {31'b0, valid_out}, 0);
        chk("rst_stall", {31'b0, stall}, 0);
        reset = 0;

        issue(ADD, 5, 7);
        @(negedge clk); idle();
        chk("add_result", result, 12);
        chk("add_zero", {31'b0, zero}, 0);
        chk("add_valid", {31'b0, valid_out}, 1);
        @(negedge clk);
        chk("add_valid_drop", {31'b0, valid_out}, 0);

        issue(SUB, 9, 9);
        @(negedge clk); issue(SLT, 32'hFFFF_FFFF, 1);
        chk("sub_result", result, 0);
        chk("sub_zero", {31'b0, zero}, 1);
        @(negedge clk); issue(NEG, 1, 0);
        chk("slt_result", result, 1);
        @(negedge clk); issue(PASSB, 0, 32'h1234);
        chk("neg_result", result, 32'hFFFF_FFFF);
        @(negedge clk); issue(AND_, 32'hF0F0_1234, 32'h0FF0_FF00);
        chk("passb_result", result, 32'h0000_1234);
        @(negedge clk); issue(OR_, 32'hF000_0001, 32'h0000_0F10);
        chk("and_result", result, 32'h00F0_1200);
        @(negedge clk); issue(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("or_result", result, 32'hF000_0F11);
        @(negedge clk); issue(ADD, 32'hFFFF_FFFF, 1);
        chk("undef_result", result, 0);
        chk("undef_zero", {31'b0, zero}, 1);
        chk("undef_valid", {31'b0, valid_out}, 1);
        @(negedge clk); idle();
        chk("add_wrap", result, 0);
        @(negedge clk);

        // Multiply with an add held on the inputs throughout the stall.
        issue(MUL, 32'h0001_0001, 32'h0001_0000);
        @(negedge clk); issue(ADD, 1, 2);
        cyc = stall ? 1 : 0;
        while (stall && cyc < 200) begin
            @(negedge clk);
            if (stall) cyc++;
        end
        chk("mult1_stall_cycles", cyc, exp_lat(32'h0001_0000));
        chk("mult1_result", result, 32'h0001_0000);
        chk("mult1_valid", {31'b0, valid_out}, 1);
        @(negedge clk); idle();
        chk("held_add_result", result, 3);
        @(negedge clk);

        // Flush at the tenth MULT cycle.
        issue(ADD, 32'h11, 32'h22);
        @(negedge clk); issue(MUL, 3, 32'h8000_0005);
        @(negedge clk); idle();
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk); flush = 0;
        chk("flush_stall", {31'b0, stall}, 0);
        chk("flush_valid", {31'b0, valid_out}, 0);
        chk("flush_result", result, 32'h33);

        flush = 1; issue(ADD, 2, 2);
        @(negedge clk); flush = 0; idle();
        chk("flush_idle_add", result, 4);

        // Reset mid-multiply.
        issue(MUL, 3, 32'h8000_0005);
        @(negedge clk); idle();
        repeat (5) @(negedge clk);
        reset = 1;
        @(negedge clk); reset = 0;
        chk("rstmid_result", result, 0);
        chk("rstmid_zero", {31'b0, zero}, 1);
        chk("rstmid_stall", {31'b0, stall}, 0);

        run_mult(3, 5, cyc);
        chk("mult35_cycles", cyc, exp_lat(5));
        chk("mult35_result", result, 15);
        chk("mult35_valid", {31'b0, valid_out}, 1);

        run_mult(9, 0, cyc);
        chk("mult90_cycles", cyc, exp_lat(0));
        chk("mult90_result", result, 0);
        chk("mult90_zero", {31'b0, zero}, 1);
        chk("mult90_valid", {31'b0, valid_out}, 1);

        run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        chk("multwrap_result", result, 1);
        run_mult(32'h0000_1234, 32'h0001_0003, cyc);
        chk("multmix_result", result, 32'h1234_369C);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
